// File: rtl/circular_fifo.sv
// Show-ahead circular-buffer FIFO: count-based full/empty, combinational accept
// strobes and head data, sticky overflow/underflow flags.
module circular_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int PTRWID = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              full,
  output logic              empty,
  output logic [CNTWID-1:0] count,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              overflow,
  output logic              underflow
);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTRWID-1:0] wr_ptr_r;
  logic [PTRWID-1:0] rd_ptr_r;
  logic [PTRWID-1:0] wr_ptr_nxt_s;
  logic [PTRWID-1:0] rd_ptr_nxt_s;
  logic [CNTWID-1:0] count_r;
  logic [CNTWID-1:0] count_nxt_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [WIDTH-1:0]  data_out_s;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTRWID-1:0] ptr_inc(input logic [PTRWID-1:0] ptr);
    if (ptr == PTRWID'(DEPTH - 1)) begin
      return {PTRWID{1'b0}};
    end else begin
      return ptr + PTRWID'(1);
    end
  endfunction

  // Status decode and accept rules; a full FIFO still accepts a push paired with a pop.
  always_comb begin
    full_s    = (count_r == CNTWID'(DEPTH));
    empty_s   = (count_r == {CNTWID{1'b0}});
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop);
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (push_ok_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNTWID'(1);
      2'b01:   count_nxt_s = count_r - CNTWID'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state; flags are sticky until reset and never gate operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {PTRWID{1'b0}};
      rd_ptr_r    <= {PTRWID{1'b0}};
      count_r     <= {CNTWID{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r | (push & full_s & ~pop);
      underflow_r <= underflow_r | (pop & empty_s);
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Show-ahead head word, forced to zero when empty.
  always_comb begin
    if (empty_s) begin
      data_out_s = {WIDTH{1'b0}};
    end else begin
      data_out_s = mem_r[rd_ptr_r];
    end
  end

  assign data_out  = data_out_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign push_ok   = push_ok_s;
  assign pop_ok    = pop_ok_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_circular_fifo.sv
// Bench for circular_fifo: DEPTH=8 and DEPTH=5 instances share stimulus, each
// checked against a queue model; a directed table covers fill/wrap/corners.
module tb_circular_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout8, dout5;
  logic       full8, empty8, full5, empty5;
  logic [3:0] count8, count5;
  logic       pok8, qok8, pok5, qok5;
  logic       ovf8, unf8, ovf5, unf5;

  int total = 0;
  int bad = 0;

  logic [7:0] q8[$];
  logic [7:0] q5[$];
  bit movf8 = 1'b0, munf8 = 1'b0, movf5 = 1'b0, munf5 = 1'b0;

  typedef struct {
    bit         p;
    bit         q;
    logic [7:0] d;
    bit         e_pok;
    bit         e_qok;
    logic [7:0] e_dout;
    int         e_cnt;
  } vec_t;
  vec_t tbl[$];

  circular_fifo #(.DEPTH(8), .WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout8), .full(full8), .empty(empty8), .count(count8),
    .push_ok(pok8), .pop_ok(qok8), .overflow(ovf8), .underflow(unf8)
  );

  circular_fifo #(.DEPTH(5), .WIDTH(8)) u5 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout5), .full(full5), .empty(empty5), .count(count5),
    .push_ok(pok5), .pop_ok(qok5), .overflow(ovf5), .underflow(unf5)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic post_check();
    check("count8", 32'(count8), 32'(q8.size()));
    check("full8", 32'(full8), 32'(q8.size() == 8));
    check("empty8", 32'(empty8), 32'(q8.size() == 0));
    check("overflow8", 32'(ovf8), 32'(movf8));
    check("underflow8", 32'(unf8), 32'(munf8));
    check("count5", 32'(count5), 32'(q5.size()));
    check("full5", 32'(full5), 32'(q5.size() == 5));
    check("empty5", 32'(empty5), 32'(q5.size() == 0));
    check("overflow5", 32'(ovf5), 32'(movf5));
    check("underflow5", 32'(unf5), 32'(munf5));
  endtask

  // Called at posedge+1; drives, checks combinational outputs, clocks, checks state.
  task automatic step(input bit p, input bit q, input logic [7:0] d,
                      output logic s_pok, output logic s_qok, output logic [7:0] s_dout);
    bit a8p, a8q, a5p, a5q;
    push = p; pop = q; data_in = d;
    #2;
    a8q = q && (q8.size() > 0);
    a8p = p && ((q8.size() < 8) || q);
    a5q = q && (q5.size() > 0);
    a5p = p && ((q5.size() < 5) || q);
    check("push_ok8", 32'(pok8), 32'(a8p));
    check("pop_ok8", 32'(qok8), 32'(a8q));
    check("data_out8", 32'(dout8), (q8.size() > 0) ? 32'(q8[0]) : 32'd0);
    check("push_ok5", 32'(pok5), 32'(a5p));
    check("pop_ok5", 32'(qok5), 32'(a5q));
    check("data_out5", 32'(dout5), (q5.size() > 0) ? 32'(q5[0]) : 32'd0);
    s_pok = pok8; s_qok = qok8; s_dout = dout8;
    if (p && !q && q8.size() == 8) movf8 = 1'b1;
    if (q && q8.size() == 0) munf8 = 1'b1;
    if (p && !q && q5.size() == 5) movf5 = 1'b1;
    if (q && q5.size() == 0) munf5 = 1'b1;
    @(posedge clk);
    if (a8q) void'(q8.pop_front());
    if (a8p) q8.push_back(d);
    if (a5q) void'(q5.pop_front());
    if (a5p) q5.push_back(d);
    #1;
    post_check();
  endtask

  // Asserts reset between edges and checks the same-cycle effect, then releases at posedge+1.
  task automatic do_reset();
    push = 1'b0; pop = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rst_count8", 32'(count8), 32'd0);
    check("rst_empty8", 32'(empty8), 32'd1);
    check("rst_full8", 32'(full8), 32'd0);
    check("rst_dout8", 32'(dout8), 32'd0);
    check("rst_flags8", 32'({ovf8, unf8}), 32'd0);
    check("rst_count5", 32'(count5), 32'd0);
    check("rst_dout5", 32'(dout5), 32'd0);
    q8.delete(); q5.delete();
    movf8 = 1'b0; munf8 = 1'b0; movf5 = 1'b0; munf5 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic add(input bit p, input bit q, input logic [7:0] d, input bit ep,
                     input bit eq, input logic [7:0] ed, input int ec);
    vec_t v;
    v.p = p; v.q = q; v.d = d; v.e_pok = ep; v.e_qok = eq; v.e_dout = ed; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic       s_pok, s_qok;
    logic [7:0] s_dout;

    // Directed fill / partial drain / wrap / corner table for the DEPTH=8 instance.
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, 8'h00, i + 1);
    for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'(j), 7 - j);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 8'(8 + k), 1'b1, 1'b0, 8'h03, 6 + k);
    add(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h03, 8);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h04, 8);
    for (int m = 0; m < 7; m++) add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'(4 + m), 7 - m);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 0);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    add(1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h66, 0);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    post_check();

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].p, tbl[n].q, tbl[n].d, s_pok, s_qok, s_dout);
      check("tbl_push_ok", 32'(s_pok), 32'(tbl[n].e_pok));
      check("tbl_pop_ok", 32'(s_qok), 32'(tbl[n].e_qok));
      check("tbl_data_out", 32'(s_dout), 32'(tbl[n].e_dout));
      check("tbl_count", 32'(count8), 32'(tbl[n].e_cnt));
    end

    // Sticky flags survive idle and legal traffic.
    for (int n = 0; n < 20; n++) begin
      step(n[0], n[0] & n[1], 8'(n), s_pok, s_qok, s_dout);
      check("sticky_ovf8", 32'(ovf8), 32'd1);
      check("sticky_unf8", 32'(unf8), 32'd1);
    end

    // Mid-stream reset with five entries held, then first word after release.
    do_reset();
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 8'(8'h90 + n), s_pok, s_qok, s_dout);
    check("pre_reset_count8", 32'(count8), 32'd5);
    do_reset();
    step(1'b1, 1'b0, 8'hA1, s_pok, s_qok, s_dout);
    #1;
    check("after_reset_dout8", 32'(dout8), 32'hA1);
    check("after_reset_count8", 32'(count8), 32'd1);
    #8;

    // Randomized traffic against the queue models.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), s_pok, s_qok, s_dout);
    end

    // DEPTH=5: 12 pushes interleaved with pops so the pointers wrap.
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(1'b1, (n % 3) == 2, 8'(8'hC0 + n), s_pok, s_qok, s_dout);
      check("count5_bound", 32'(count5 <= 4'd5), 32'd1);
    end
    while (q5.size() > 0) step(1'b0, 1'b1, 8'h00, s_pok, s_qok, s_dout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
